// File: rtl/switch_counter.sv
// Three push-buttons (increment / decrement / clear) drive a 4-bit counter shown on four LEDs.
// Each button is synchronized, debounced and turned into a one-cycle press pulse before it reaches the count.

module switch_debounce #(
   parameter int DEBOUNCE_LIMIT = 250_000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Press
);

   localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             level;
   logic             level_q;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         o_Press <= 1'b0;
      end else begin
         sync    <= {sync[0], i_Switch};
         level_q <= level;
         o_Press <= level & ~level_q;
         // Any return to the accepted level restarts the stability window.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

module switch_counter #(
   parameter int DEBOUNCE_LIMIT = 250_000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   input  logic i_Switch_3,
   output logic o_LED_1,
   output logic o_LED_2,
   output logic o_LED_3,
   output logic o_LED_4
);

   localparam int NUM_SW = 3;
   localparam int SW_INC = 0;
   localparam int SW_DEC = 1;
   localparam int SW_CLR = 2;

   logic [NUM_SW-1:0] sw;
   logic [NUM_SW-1:0] press;
   logic [3:0]        count;

   assign sw = {i_Switch_3, i_Switch_2, i_Switch_1};

   switch_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
   ) u_db [NUM_SW-1:0] (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Switch(sw),
      .o_Press (press)
   );

   // Clear wins; simultaneous inc and dec cancel out. 4-bit arithmetic wraps naturally.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         count <= '0;
      end else if (press[SW_CLR]) begin
         count <= '0;
      end else if (press[SW_INC] && !press[SW_DEC]) begin
         count <= count + 4'd1;
      end else if (press[SW_DEC] && !press[SW_INC]) begin
         count <= count - 4'd1;
      end
   end

   assign o_LED_1 = count[3];
   assign o_LED_2 = count[2];
   assign o_LED_3 = count[1];
   assign o_LED_4 = count[0];

endmodule

// File: tb/tb_switch_counter.sv
// Directed scenarios plus random button activity for switch_counter, checked against
// constants and an event-level reference model of debounce and counting.

module tb_switch_counter;

   localparam int DL = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic sw1, sw2, sw3;
   logic led1, led2, led3, led4;
   logic [3:0] leds;

   int checks = 0;
   int errors = 0;

   switch_counter #(
      .DEBOUNCE_LIMIT(DL)
   ) dut (
      .i_Clk     (clk),
      .i_Rst_L   (rst_n),
      .i_Switch_1(sw1),
      .i_Switch_2(sw2),
      .i_Switch_3(sw3),
      .o_LED_1   (led1),
      .o_LED_2   (led2),
      .o_LED_3   (led3),
      .o_LED_4   (led4)
   );

   always #5 clk = ~clk;

   assign leds = {led1, led2, led3, led4};

   // Reference model: a level is accepted after DL consecutive edges seeing the
   // synchronized (two-edge delayed) raw value differ from the accepted one; an
   // accepted rise takes effect on the count two edges later.
   int m_dly [3][2];
   int m_acc [3];
   int m_run [3];
   int m_due [3];
   int m_fire[3];
   int m_raw [3];
   int m_d2;
   int m_count;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_dly[i][0] = 0; m_dly[i][1] = 0;
            m_acc[i] = 0; m_run[i] = 0; m_due[i] = 0;
         end
         m_count = 0;
      end else begin
         m_raw[0] = int'(sw1); m_raw[1] = int'(sw2); m_raw[2] = int'(sw3);
         for (int i = 0; i < 3; i++) begin
            m_fire[i] = 0;
            if (m_due[i] > 0) begin
               m_due[i]--;
               if (m_due[i] == 0) m_fire[i] = 1;
            end
            m_d2 = m_dly[i][1];
            m_dly[i][1] = m_dly[i][0];
            m_dly[i][0] = m_raw[i];
            if (m_d2 != m_acc[i]) begin
               m_run[i]++;
               if (m_run[i] == DL) begin
                  m_acc[i] = m_d2;
                  m_run[i] = 0;
                  if (m_d2 == 1) m_due[i] = 2;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         if (m_fire[2] == 1)                         m_count = 0;
         else if (m_fire[0] == 1 && m_fire[1] == 0) m_count = (m_count + 1) % 16;
         else if (m_fire[1] == 1 && m_fire[0] == 0) m_count = (m_count + 15) % 16;
      end
   end

   task automatic chk(input string tag, input logic [3:0] exp);
      checks++;
      assert (leds === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, leds, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("model", 4'(m_count));
      end
   endtask

   task automatic set_sw(input logic [2:0] m);
      sw1 = m[0];
      sw2 = m[1];
      sw3 = m[2];
   endtask

   task automatic press(input logic [2:0] m);
      set_sw(m);
      tick(10);
      set_sw(3'b000);
      tick(10);
   endtask

   initial begin
      rst_n = 1'b0;
      set_sw(3'b000);
      tick(3);
      chk("reset", 4'd0);
      rst_n = 1'b1;
      tick(1);

      // short glitch is ignored
      sw1 = 1'b1;
      tick(3);
      sw1 = 1'b0;
      tick(12);
      chk("glitch", 4'd0);

      // single held press: change on the 8th edge counting the first high sample
      sw1 = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         chk("single", (k >= 8) ? 4'd1 : 4'd0);
      end
      sw1 = 1'b0;
      tick(10);
      chk("single_rel", 4'd1);

      // wrap up through 15 to 0, then down from 0 to 15
      press(3'b100);
      chk("clear", 4'd0);
      for (int k = 1; k <= 16; k++) begin
         press(3'b001);
         chk("wrap_up", 4'(k));
      end
      press(3'b010);
      chk("wrap_dn", 4'd15);

      // simultaneous events
      press(3'b100);
      repeat (5) press(3'b001);
      chk("to5", 4'd5);
      press(3'b011);
      chk("inc_dec", 4'd5);
      press(3'b101);
      chk("inc_clr", 4'd0);

      // async reset mid-debounce, switch held through release
      repeat (9) press(3'b001);
      chk("to9", 4'd9);
      sw1 = 1'b1;
      tick(3);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 4'd0);
      tick(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         chk("rst_hold", (k >= 8) ? 4'd1 : 4'd0);
      end
      sw1 = 1'b0;
      tick(10);
      chk("rst_rel", 4'd1);

      // bouncing decrement settles into one press
      press(3'b100);
      repeat (3) press(3'b001);
      chk("to3", 4'd3);
      for (int k = 0; k < 30; k++) begin
         sw2 = ((k / 2) % 2) == 0;
         tick(1);
      end
      sw2 = 1'b1;
      tick(12);
      sw2 = 1'b0;
      tick(10);
      chk("bounce", 4'd2);

      // random activity, mostly quiet so many presses are clean
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 2) == 0) set_sw(3'b000);
         else set_sw(3'($urandom_range(0, 7)));
         tick(int'($urandom_range(1, 9)));
      end
      set_sw(3'b000);
      tick(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
